sc_dot_product_core: RTL and testbench

//   Stochastic-computing dot product of two DIMENSION-element bitstream vectors.

---
 rtl/sc_dot_product_core.sv | 64 ++++++
 tb/tb_sc_dot_product_core.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/sc_dot_product_core.sv
// Stochastic-computing dot product: XNOR multiply per lane, mux-based 1/DIMENSION scaled add.
// Latency: 1 cycle (inputs sampled at edge k appear on result after edge k).
// Backpressure: none; one output stream bit every cycle, valid held high after reset.
//
// Ports:
//   clk     - rising-edge clock
//   rst     - asynchronous active-low reset; clears result and valid
//   data    - one bit per data stream for the current cycle
//   weights - one bit per weight stream for the current cycle
//   sel     - concatenated p=0.5 random select streams (lane select for the scaled add)
//   result  - output stream bit, encoding sum(x_i*w_i)/DIMENSION in bipolar form
//   valid   - high once the first post-reset edge has loaded result
module sc_dot_product_core #(
  parameter int DIMENSION    = 4,
  parameter int SELECT_WIDTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DIMENSION-1:0]    data,
  input  logic [DIMENSION-1:0]    weights,
  input  logic [SELECT_WIDTH-1:0] sel,
  output logic                    result,
  output logic                    valid
);

  logic [DIMENSION-1:0] prod;
  logic                 mux_out;
  logic                 result_d, result_q;
  logic                 valid_d, valid_q;

  // Bipolar stochastic multiply: the product bit is 1 when both operands agree.
  assign prod = ~(data ^ weights);

  // Scaled add: picking one lane uniformly at random averages the products,
  // i.e. divides their sum by DIMENSION. Select codes with no matching lane
  // (only possible for non-power-of-2 DIMENSION) fall through to 0.
  always_comb begin
    mux_out = 1'b0;
    for (int i = 0; i < DIMENSION; i++) begin
      if (sel == i[SELECT_WIDTH-1:0]) begin
        mux_out = prod[i];
      end
    end
  end

  always_comb begin
    result_d = mux_out;
    valid_d  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign result = result_q;
  assign valid  = valid_q;

endmodule

// File: tb/tb_sc_dot_product_core.sv
module tb_sc_dot_product_core;

  logic       clk;
  logic       rst;
  logic [3:0] data;
  logic [3:0] weights;
  logic [1:0] sel;
  logic       result;
  logic       valid;

  int checks;
  int errors;

  sc_dot_product_core #(
    .DIMENSION   (4),
    .SELECT_WIDTH(2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .data   (data),
    .weights(weights),
    .sel    (sel),
    .result (result),
    .valid  (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic model(input logic [3:0] d, input logic [3:0] w, input logic [1:0] s);
    return ~(d[s] ^ w[s]);
  endfunction

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic rand_inputs();
    data    = 4'($urandom);
    weights = 4'($urandom);
    sel     = 2'($urandom);
  endtask

  // Bipolar stream bit with P(1) = k/4.
  function automatic logic pbit(input int k);
    return ($urandom_range(0, 3) < k) ? 1'b1 : 1'b0;
  endfunction

  initial begin
    logic       exp_r;
    logic [3:0] exp_pat;
    int         ones;
    real        decoded;
    logic       in_tol;

    checks  = 0;
    errors  = 0;
    rst     = 1'b0;
    data    = 4'd0;
    weights = 4'd0;
    sel     = 2'd0;

    // 1. Reset held for 8 cycles with random inputs.
    for (int i = 0; i < 8; i++) begin
      rand_inputs();
      tick();
      chk("reset_result", result, 1'b0);
      chk("reset_valid", valid, 1'b0);
    end
    rst     = 1'b1;
    data    = 4'b0011;
    weights = 4'b0101;
    sel     = 2'd3;            // lane 3: 0 vs 0 agree -> 1
    tick();
    chk("release_valid", valid, 1'b1);
    chk("release_result", result, 1'b1);

    // 2. Exhaustive select: p = ~(1010 ^ 1100) = 1001.
    data    = 4'b1010;
    weights = 4'b1100;
    exp_pat = 4'b1001;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      tick();
      chk($sformatf("sel%0d", s), result, exp_pat[s]);
      chk("sel_valid", valid, 1'b1);
    end

    // 3. All-agree, then all-disagree.
    for (int i = 0; i < 6; i++) begin
      weights = 4'($urandom);
      data    = weights;
      sel     = 2'($urandom);
      tick();
      chk("agree", result, 1'b1);
    end
    for (int i = 0; i < 6; i++) begin
      weights = 4'($urandom);
      data    = ~weights;
      sel     = 2'($urandom);
      tick();
      chk("disagree", result, 1'b0);
    end

    // Inputs changed between edges must not disturb result.
    data    = 4'b1111;
    weights = 4'b1111;
    sel     = 2'd0;
    tick();
    data    = 4'b0000;
    weights = 4'b1111;
    #2;
    chk("between_edges", result, 1'b1);

    // 4. Golden stream.
    for (int i = 0; i < 100; i++) begin
      rand_inputs();
      exp_r = model(data, weights, sel);
      tick();
      chk("golden", result, exp_r);
      chk("golden_valid", valid, 1'b1);
    end

    // 5. Mid-stream asynchronous reset.
    data    = 4'b0110;
    weights = 4'b0110;
    sel     = 2'd1;
    tick();
    chk("pre_reset_result", result, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset_result", result, 1'b0);
    chk("async_reset_valid", valid, 1'b0);
    tick();
    chk("held_reset_valid", valid, 1'b0);
    chk("held_reset_result", result, 1'b0);
    rst     = 1'b1;
    data    = 4'b0100;
    weights = 4'b1111;
    sel     = 2'd2;            // lane 2: 1 vs 1 agree -> 1
    tick();
    chk("post_reset_valid", valid, 1'b1);
    chk("post_reset_result", result, 1'b1);
    data    = 4'b0100;
    weights = 4'b1011;
    sel     = 2'd2;            // lane 2: 1 vs 0 disagree -> 0
    tick();
    chk("post_reset_next", result, 1'b0);

    // 6. Statistics: x=(0.5,-0.5,1,0), w=(1,1,-0.5,0.5) -> expect -0.125.
    ones = 0;
    for (int i = 0; i < 4096; i++) begin
      data    = {pbit(2), pbit(4), pbit(1), pbit(3)};
      weights = {pbit(3), pbit(1), pbit(4), pbit(4)};
      sel     = 2'($urandom);
      tick();
      if (result === 1'b1) ones++;
    end
    decoded = 2.0 * real'(ones) / 4096.0 - 1.0;
    in_tol  = ((decoded + 0.125) <= 0.05 && (decoded + 0.125) >= -0.05) ? 1'b1 : 1'b0;
    $display("stats decoded=%f target=-0.125", decoded);
    chk("stats_decoded", in_tol, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
